// File: rtl/rc4_decrypt_prga.sv
// RC4 keystream generator: swaps through the S table and writes f ^ ciphertext to the plaintext RAM.
// Nine cycles per byte and done in cycle 9*MSG_LEN+1 after start. The memories are assumed always ready, so there is no backpressure.
module rc4_decrypt_prga #(
  parameter int MSG_LEN = 32,
  parameter int MSG_AW  = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [7:0]        s_address,
  output logic [7:0]        s_data,
  output logic              s_wren,
  input  logic [7:0]        s_q,
  output logic [MSG_AW-1:0] rom_address,
  input  logic [7:0]        rom_q,
  output logic [MSG_AW-1:0] dec_address,
  output logic [7:0]        dec_data,
  output logic              dec_wren
);

  typedef enum logic [3:0] {
    IDLE,
    RD_I,
    GET_I,
    RD_J,
    GET_J,
    WR_I,
    WR_J,
    RD_F,
    GET_F,
    WR_D,
    DONE
  } state_t;

  localparam logic [MSG_AW-1:0] K_LAST = MSG_AW'(MSG_LEN - 1);

  state_t            state;
  state_t            state_nxt;
  logic [7:0]        i;
  logic [7:0]        j;
  logic [7:0]        si;
  logic [7:0]        sj;
  logic [7:0]        f;
  logic [7:0]        enc;
  logic [MSG_AW-1:0] k;
  logic              last_byte;

  assign last_byte = (k == K_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    busy        = 1'b1;
    done        = 1'b0;
    s_address   = 8'h00;
    s_data      = 8'h00;
    s_wren      = 1'b0;
    rom_address = k;
    dec_address = k;
    dec_data    = 8'h00;
    dec_wren    = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nxt = RD_I;
        end
      end
      RD_I: begin
        s_address = i;
        state_nxt = GET_I;
      end
      GET_I: state_nxt = RD_J;
      RD_J: begin
        s_address = j;
        state_nxt = GET_J;
      end
      GET_J: state_nxt = WR_I;
      WR_I: begin
        s_address = i;
        s_data    = sj;
        s_wren    = 1'b1;
        state_nxt = WR_J;
      end
      WR_J: begin
        s_address = j;
        s_data    = si;
        s_wren    = 1'b1;
        state_nxt = RD_F;
      end
      RD_F: begin
        // 8-bit sum: the carry out of si+sj is intentionally dropped
        s_address = si + sj;
        state_nxt = GET_F;
      end
      GET_F: state_nxt = WR_D;
      WR_D: begin
        dec_data  = f ^ enc;
        dec_wren  = 1'b1;
        state_nxt = last_byte ? DONE : RD_I;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      i   <= 8'h00;
      j   <= 8'h00;
      k   <= '0;
      si  <= 8'h00;
      sj  <= 8'h00;
      f   <= 8'h00;
      enc <= 8'h00;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            i <= 8'h01;
            j <= 8'h00;
            k <= '0;
          end
        end
        GET_I: begin
          si  <= s_q;
          j   <= j + s_q;
          enc <= rom_q;
        end
        GET_J: sj <= s_q;
        GET_F: f <= s_q;
        WR_D: begin
          if (!last_byte) begin
            k <= k + 1'b1;
            i <= i + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_decrypt_prga.sv
// Bench for rc4_decrypt_prga: memory models, directed vectors, scoreboard of expected plaintext writes.
module tb_rc4_decrypt_prga;
  localparam int MSG_LEN = 32;
  localparam int MSG_AW  = 5;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              busy;
  logic              done;
  logic [7:0]        s_address;
  logic [7:0]        s_data;
  logic              s_wren;
  logic [7:0]        s_q;
  logic [MSG_AW-1:0] rom_address;
  logic [7:0]        rom_q;
  logic [MSG_AW-1:0] dec_address;
  logic [7:0]        dec_data;
  logic              dec_wren;

  rc4_decrypt_prga #(.MSG_LEN(MSG_LEN), .MSG_AW(MSG_AW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
    .s_address(s_address), .s_data(s_data), .s_wren(s_wren), .s_q(s_q),
    .rom_address(rom_address), .rom_q(rom_q),
    .dec_address(dec_address), .dec_data(dec_data), .dec_wren(dec_wren)
  );

  always #5 clk = ~clk;

  logic [7:0] smem [256];
  logic [7:0] s_init [256];
  logic       s_load = 1'b0;
  logic [7:0] rom [MSG_LEN];
  logic [7:0] dec [MSG_LEN];

  // synchronous memories: address in cycle N, data visible in cycle N+1
  always @(posedge clk) begin
    if (s_load) begin
      for (int n = 0; n < 256; n++) smem[n] <= s_init[n];
    end else if (s_wren) begin
      smem[s_address] <= s_data;
    end
    s_q   <= smem[s_address];
    rom_q <= rom[rom_address];
    if (dec_wren) dec[dec_address] <= dec_data;
  end

  int cyc = 0;
  int start_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc - start_cyc + 1);
    end
  endtask

  typedef struct {
    int addr;
    int data;
    int cyc;
  } exp_t;
  exp_t exp_q[$];

  // reference RC4 PRGA over a snapshot of the S memory
  logic [7:0] m_s [256];
  logic [7:0] m_ks [MSG_LEN];
  logic [7:0] m_out [MSG_LEN];

  task automatic model_run();
    logic [7:0] mi;
    logic [7:0] mj;
    logic [7:0] t;
    logic [7:0] fi;
    for (int n = 0; n < 256; n++) m_s[n] = smem[n];
    mi = 8'h00;
    mj = 8'h00;
    for (int n = 0; n < MSG_LEN; n++) begin
      mi = mi + 8'd1;
      mj = mj + m_s[mi];
      t = m_s[mi];
      m_s[mi] = m_s[mj];
      m_s[mj] = t;
      fi = m_s[mi] + m_s[mj];
      m_ks[n] = m_s[fi];
      m_out[n] = m_ks[n] ^ rom[n];
    end
  endtask

  // monitor: pops the scoreboard on every plaintext write
  exp_t e;
  int   rel;
  int   wr_cnt = 0;
  int   done_cnt = 0;
  int   onehot_bad = 0;
  always @(negedge clk) begin
    rel = cyc - start_cyc + 1;
    if (dec_wren) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL dec_unexpected: write addr %0d data 0x%0h with nothing expected", dec_address, dec_data);
      end else begin
        e = exp_q.pop_front();
        check("dec_addr", dec_address, e.addr);
        check("dec_data", dec_data, e.data);
        check("dec_cycle", rel, e.cyc);
      end
    end
    if (done) done_cnt++;
    if ((32'(s_wren) + 32'(dec_wren) + 32'(done)) > 1) onehot_bad++;
  end

  task automatic load_s();
    @(negedge clk);
    s_load = 1'b1;
    @(negedge clk);
    s_load = 1'b0;
  endtask

  task automatic wait_rel(input int r);
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (cyc - start_cyc + 1 == r) return;
    end
    total++;
    bad++;
    $display("FAIL wait_rel: cycle %0d never reached", r);
  endtask

  task automatic start_run(input bit hold);
    @(negedge clk);
    check("idle_busy", busy, 0);
    start = 1'b1;
    model_run();
    @(posedge clk);
    #1;
    start_cyc = cyc;
    if (!hold) start = 1'b0;
    for (int n = 0; n < MSG_LEN; n++) begin
      exp_t x;
      x.addr = n;
      x.data = m_out[n];
      x.cyc  = 9 * n + 9;
      exp_q.push_back(x);
    end
    wait_rel(1);
    check("busy_rise", busy, 1);
  endtask

  int wr0;
  int dn0;
  task automatic finish_run();
    wait_rel(289);
    check("done_at_289", done, 1);
    wait_rel(290);
    check("done_single", done, 0);
    check("busy_290", busy, 0);
    check("done_count", done_cnt - dn0, 1);
    check("wr_count", wr_cnt - wr0, MSG_LEN);
    check("sb_drain", exp_q.size(), 0);
  endtask

  task automatic check_s_final(input string name);
    int nb = 0;
    for (int n = 0; n < 256; n++) if (smem[n] !== m_s[n]) nb++;
    check(name, nb, 0);
  endtask

  task automatic mark();
    wr0 = wr_cnt;
    dn0 = done_cnt;
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    #1;
    check("rst_s_wren", s_wren, 0);
    check("rst_dec_wren", dec_wren, 0);
    check("rst_busy", busy, 0);
    check("rst_dec_addr", dec_address, 0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  logic [7:0] kvec [9];
  logic [7:0] key [3];
  string      pt;

  initial begin
    logic [7:0] jj;
    logic [7:0] t;
    kvec = '{8'h9B, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    key  = '{8'h4B, 8'h65, 8'h79};
    pt   = "plaintextdecryptedbythercfourprg";

    // reset values
    repeat (3) @(negedge clk);
    check("rst_busy0", busy, 0);
    check("rst_done0", done, 0);
    check("rst_s_wren0", s_wren, 0);
    check("rst_dec_wren0", dec_wren, 0);
    check("rst_s_addr0", s_address, 0);
    check("rst_s_data0", s_data, 0);
    check("rst_rom_addr0", rom_address, 0);
    check("rst_dec_addr0", dec_address, 0);
    check("rst_dec_data0", dec_data, 0);
    reset_n = 1'b1;

    // identity S, zero ciphertext
    for (int n = 0; n < 256; n++) s_init[n] = 8'(n);
    for (int n = 0; n < MSG_LEN; n++) rom[n] = 8'h00;
    load_s();
    mark();
    start_run(0);
    wait_rel(28);
    check("s2_after_b2", smem[2], 8'h03);
    check("s3_after_b2", smem[3], 8'h05);
    check("s5_after_b2", smem[5], 8'h02);
    finish_run();
    check("a_dec0", dec[0], 8'h02);
    check("a_dec1", dec[1], 8'h05);
    check("a_dec2", dec[2], 8'h07);
    check_s_final("a_s_final");

    // identity S, 0xFF ciphertext, start held across DONE
    for (int n = 0; n < MSG_LEN; n++) rom[n] = 8'hFF;
    load_s();
    mark();
    start_run(1);
    finish_run();
    check("b_dec0", dec[0], 8'hFD);
    check("b_dec1", dec[1], 8'hFA);
    check("b_dec2", dec[2], 8'hF8);
    wait_rel(291);
    check("b_held_restart", busy, 1);
    start = 1'b0;
    pulse_reset();

    // f index wrap: si+sj = 0xF0+0x20
    for (int n = 0; n < 256; n++) s_init[n] = 8'(n);
    s_init[1] = 8'hF0;
    s_init[8'hF0] = 8'h20;
    for (int n = 0; n < MSG_LEN; n++) rom[n] = 8'h00;
    load_s();
    mark();
    start_run(0);
    wait_rel(7);
    check("c_f_wrap_addr", s_address, 8'h10);
    finish_run();
    check("c_dec0", dec[0], 8'h10);
    check_s_final("c_s_final");

    // known key "Key": KSA, published ciphertext head, lowercase plaintext
    for (int n = 0; n < 256; n++) s_init[n] = 8'(n);
    jj = 8'h00;
    for (int n = 0; n < 256; n++) begin
      jj = jj + s_init[n] + key[n % 3];
      t = s_init[n];
      s_init[n] = s_init[jj];
      s_init[jj] = t;
    end
    for (int n = 0; n < MSG_LEN; n++) rom[n] = 8'h00;
    load_s();
    model_run();
    for (int n = 0; n < MSG_LEN; n++) rom[n] = (n < 9) ? kvec[n] : (m_ks[n] ^ pt[n]);
    mark();
    start_run(0);
    finish_run();
    for (int n = 0; n < MSG_LEN; n++) check("d_plain", dec[n], pt[n]);
    check_s_final("d_s_final");

    // reset during byte 10, then restart with start pulses while busy
    mark();
    start_run(0);
    wait_rel(95);
    check("e_wr_i_active", s_wren, 1);
    #1;
    pulse_reset();
    mark();
    start_run(0);
    wait_rel(20);
    start = 1'b1;
    wait_rel(21);
    start = 1'b0;
    check("e_busy_ignore1", busy, 1);
    wait_rel(150);
    start = 1'b1;
    wait_rel(151);
    start = 1'b0;
    check("e_busy_ignore2", busy, 1);
    finish_run();
    check_s_final("e_s_final");

    check("onehot_enables", onehot_bad, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rc4_decrypt_prga.md
# rc4_decrypt_prga

RC4 keystream generator and decrypt stage (PRGA). It runs after the key-schedule shuffle has left a permuted S table in the 256x8 S memory. It walks the S table, swapping entries and forming keystream bytes, and XORs each keystream byte with the matching ciphertext byte from the encrypted-message ROM. Each plaintext byte is written to the decrypted-message RAM. The control FSM grants this block the S-memory port in its COMPUTE phase and waits on `done`.

## Interface
Parameters:
- `MSG_LEN`, 32: number of message bytes processed.
- `MSG_AW`, 5: message ROM/RAM address width. Must satisfy `2**MSG_AW >= MSG_LEN`.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin decrypt. Sampled only in IDLE.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the last byte has been written.
- `s_address`  out  8  S memory address.
- `s_data`  out  8  S memory write data.
- `s_wren`  out  1  S memory write enable.
- `s_q`  in  8  S memory read data.
- `rom_address`  out  MSG_AW  ciphertext ROM address.
- `rom_q`  in  8  ciphertext byte.
- `dec_address`  out  MSG_AW  plaintext RAM address.
- `dec_data`  out  8  plaintext byte.
- `dec_wren`  out  1  plaintext RAM write enable.

## Operation
- Registers: `i`, `j` and `k` are 8-bit, 8-bit and MSG_AW-bit counters. `si`, `sj`, `f` and `enc` are 8-bit holding registers.
- Memory model: all memories are synchronous. An address driven in cycle N returns q that is sampled in cycle N+1.
- All outputs are decoded from state and registers only. There is no combinational path from any input to any output.
- States and per-state actions:
  - IDLE: all enables low. If `start`: set i=1, j=0, k=0 and go to RD_I.
  - RD_I: `s_address`=i, `rom_address`=k.
  - GET_I: si<=s_q, j<=j+s_q (mod 256), enc<=rom_q.
  - RD_J: `s_address`=j.
  - GET_J: sj<=s_q.
  - WR_I: `s_address`=i, `s_data`=sj, `s_wren`=1.
  - WR_J: `s_address`=j, `s_data`=si, `s_wren`=1.
  - RD_F: `s_address`=si+sj (mod 256, 8-bit wrap).
  - GET_F: f<=s_q.
  - WR_D: `dec_address`=k, `dec_data`=f^enc, `dec_wren`=1. If k==MSG_LEN-1, go to DONE. Otherwise k<=k+1, i<=i+1 (mod 256), go to RD_I.
  - DONE: `done`=1, then go to IDLE.
- In all other states the next state is the listed successor, unconditionally.
- Swap when i==j: both writes hit the same address with the same value. This is legal and needs no special case.
- f index wrap: `si+sj` overflowing 255 drops the carry, so the index is 8-bit.
- `start` while busy is ignored. `start` held high across DONE->IDLE begins a new run one cycle after IDLE.
- In the idle and non-write states, `s_data` and `dec_data` are don't-care but driven; `s_wren` and `dec_wren` are 0.

## Timing
- Reset values: state=IDLE; `busy`=0, `done`=0, `s_wren`=0, `dec_wren`=0. All addresses, data outputs and internal registers are 0.
- Reset asserted mid-run: return to IDLE immediately and asynchronously, with all enables low. A partially written plaintext RAM is acceptable. The next `start` restarts from k=0, and the S table is not restored.
- Per-byte cost: 9 cycles (RD_I through WR_D).
- Latency: if `start` is sampled at edge E0, RD_I occupies the cycle after E0. `dec_wren` for byte k is high in cycle 9k+9, and `done` is high in cycle 9·MSG_LEN+1. With the default that is cycle 289.
- Write ordering: WR_I precedes WR_J, and both precede RD_F, so the f read sees the swapped table.
- Exactly one `dec_wren` pulse per byte. Two `s_wren` pulses per byte. Never more than one enable high in a cycle.

## Test plan
- Identity S (s[n]=n), ciphertext all 0x00, MSG_LEN=32 -> dec[0]=0x02, dec[1]=0x05, dec[2]=0x07. After byte 2, S[2]=0x03, S[3]=0x05, S[5]=0x02. The remaining bytes match a C reference model.
- Identity S, ciphertext all 0xFF -> dec[0]=0xFD, dec[1]=0xFA, dec[2]=0xF8. Exactly 32 `dec_wren` pulses, at addresses 0..31 in order.
- Latency: `start` sampled at edge E0 -> `busy` rises the next cycle. `done` is a single-cycle pulse in cycle 289, and `busy` is low in cycle 290.
- Known-key S from a golden KSA dump plus the matching lab ciphertext -> RAM holds the expected lowercase plaintext byte-for-byte. The S memory final state matches the model.
- Wrap check: preload S with s[1]=0xF0, s[0xF0]=0x20 (rest identity) -> j=0xF0, f index = 0x110 & 0xFF = 0x10. The bench checks that `s_address` in RD_F equals 0x10.
- Pulse `reset_n` low during byte 10 -> all enables drop in the same cycle and state is IDLE. A new `start` rewrites from `dec_address`=0, and `start` pulses while busy produce no restart.
